// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-output signals of the 4x4 keypad scanner.
// master = scanner, slave = keypad matrix / downstream display stage.
interface keypad_scanner_if;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [1:0] state_dbg;

   modport master (input col, output row, key_code, key_valid, key_held, state_dbg);
   modport slave  (output col, input row, key_code, key_valid, key_held, state_dbg);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, ghost rejection and frame-based
// press/release debouncing, producing a one-cycle key_valid per accepted press.
module keypad_scanner #(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic             clk,
   input  logic             reset,
   keypad_scanner_if.master kp
);
   localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   logic [3:0]    col_m, col_s;
   logic [DW-1:0] div;
   logic [1:0]    row_idx;
   logic          tc, frame_end;

   // Hit count saturates at 2: anything beyond one set bit is a ghost frame.
   logic [1:0]    acc_hits;
   logic [3:0]    acc_code;
   logic [2:0]    samp_pop, tot_hits;
   logic [1:0]    samp_idx;
   logic [1:0]    frame_hits;
   logic [3:0]    frame_code;
   logic          frame_key;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n, cnt_inc;
   logic [3:0]    pend, pend_n;
   logic [3:0]    code_q, code_n;
   logic          valid_q, valid_n;
   logic          held_q, held_n;
   logic          accept, release_done;

   assign tc        = (div == DIV_LAST);
   assign frame_end = tc && (row_idx == 2'd3);

   assign samp_pop = 3'(col_s[0]) + 3'(col_s[1]) + 3'(col_s[2]) + 3'(col_s[3]);
   assign tot_hits = 3'(acc_hits) + samp_pop;

   always_comb begin
      samp_idx = 2'd0;
      for (int j = 3; j >= 0; j--) begin
         if (col_s[j]) samp_idx = 2'(j);
      end
   end

   assign frame_hits = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
   assign frame_code = (samp_pop == 3'd1) ? {row_idx, samp_idx} : acc_code;
   assign frame_key  = (frame_hits == 2'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_m    <= 4'd0;
         col_s    <= 4'd0;
         div      <= '0;
         row_idx  <= 2'd0;
         acc_hits <= 2'd0;
         acc_code <= 4'd0;
      end else begin
         col_m <= kp.col;
         col_s <= col_m;
         if (tc) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
            if (row_idx == 2'd3) begin
               acc_hits <= 2'd0;
               acc_code <= 4'd0;
            end else begin
               acc_hits <= frame_hits;
               acc_code <= frame_code;
            end
         end else begin
            div <= div + DW'(1);
         end
      end
   end

   assign kp.row = 4'b0001 << row_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         pend    <= 4'd0;
         code_q  <= 4'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         pend    <= pend_n;
         code_q  <= code_n;
         valid_q <= valid_n;
         held_q  <= held_n;
      end
   end

   // The debounce FSM only moves on frame-end edges; between them it holds.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      pend_n       = pend;
      code_n       = code_q;
      valid_n      = 1'b0;
      held_n       = held_q;
      accept       = 1'b0;
      release_done = 1'b0;
      cnt_inc      = cnt + 4'd1;
      if (frame_end) begin
         case (state)
            IDLE: begin
               if (frame_key) begin
                  state_n = PRESS_WAIT;
                  pend_n  = frame_code;
                  cnt_n   = 4'd1;
                  if (cnt_n == DB_LAST) accept = 1'b1;
               end
            end
            PRESS_WAIT: begin
               if (!frame_key) begin
                  state_n = IDLE;
                  cnt_n   = 4'd0;
               end else begin
                  if (frame_code == pend) begin
                     cnt_n = cnt_inc;
                  end else begin
                     pend_n = frame_code;
                     cnt_n  = 4'd1;
                  end
                  if (cnt_n == DB_LAST) accept = 1'b1;
               end
            end
            HELD: begin
               if (!(frame_key && (frame_code == code_q))) begin
                  state_n = RELEASE_WAIT;
                  cnt_n   = 4'd1;
                  if (cnt_n == DB_LAST) release_done = 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (frame_key && (frame_code == code_q)) begin
                  state_n = HELD;
                  cnt_n   = 4'd0;
               end else begin
                  cnt_n = cnt_inc;
                  if (cnt_n == DB_LAST) release_done = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end
         endcase
         if (accept) begin
            state_n = HELD;
            cnt_n   = 4'd0;
            code_n  = pend_n;
            valid_n = 1'b1;
            held_n  = 1'b1;
         end
         if (release_done) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            held_n  = 1'b0;
         end
      end
   end

   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;
   assign kp.state_dbg = state;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed frame table, reset corner cases and
// random key frames compared against a frame-level debounce model.
module tb_keypad_scanner;
   localparam int SCAN_DIV = 4;
   localparam int DB       = 3;
   localparam int FRAME    = 4 * SCAN_DIV;

   typedef struct {
      logic [15:0] keys;
      int          reps;
      logic        valid;
      logic        held;
      logic [3:0]  code;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   keypad_scanner_if kif ();

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kif)
   );

   // Keypad matrix: bit r*4+c of keys closes row r to column c.
   logic [15:0] keys;
   logic        rand_mode;
   logic [3:0]  rand_col;

   always_comb begin
      kif.col = 4'd0;
      if (rand_mode) begin
         kif.col = rand_col;
      end else begin
         for (int r = 0; r < 4; r++) begin
            if (kif.row[r]) kif.col = kif.col | keys[r*4 +: 4];
         end
      end
   end

   int         n_checks;
   int         n_fail;
   logic [5:0] exp_q[$];
   logic       cur_held;
   logic [3:0] cur_code;

   logic       m_held;
   logic [3:0] m_code;
   logic [3:0] m_skey;
   int         m_slen;
   int         m_miss;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level behaviour: a frame is a key only if exactly one switch is closed.
   task automatic model_step(input logic [15:0] k, output logic [5:0] e);
      logic       is_key;
      logic [3:0] c;
      logic       v;
      is_key = ($countones(k) == 1);
      c = 4'd0;
      v = 1'b0;
      for (int i = 0; i < 16; i++) if (k[i]) c = 4'(i);
      if (!m_held) begin
         if (is_key) begin
            if (m_slen > 0 && c == m_skey) m_slen++;
            else m_slen = 1;
            m_skey = c;
            if (m_slen >= DB) begin
               m_held = 1'b1;
               m_code = c;
               v      = 1'b1;
               m_slen = 0;
            end
         end else begin
            m_slen = 0;
         end
      end else begin
         if (is_key && c == m_code) m_miss = 0;
         else m_miss++;
         if (m_miss >= DB) begin
            m_held = 1'b0;
            m_miss = 0;
            m_slen = 0;
         end
      end
      e = {v, m_held, m_code};
   endtask

   // Runs one frame from a frame boundary; outputs may only change on its last edge.
   task automatic run_frame(input logic [15:0] k);
      logic [5:0] e;
      keys = k;
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge clk);
         if (c < FRAME) begin
            check("key_valid_mid", kif.key_valid, 8'd0);
            check("key_held_mid", kif.key_held, cur_held);
            check("key_code_mid", kif.key_code, cur_code);
         end else if (exp_q.size() == 0) begin
            check("exp_q_empty", 8'd1, 8'd0);
         end else begin
            e = exp_q.pop_front();
            check("key_valid_end", kif.key_valid, e[5]);
            check("key_held_end", kif.key_held, e[4]);
            check("key_code_end", kif.key_code, e[3:0]);
            cur_held = e[4];
            cur_code = e[3:0];
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_row"}, kif.row, 8'h01);
      check({tag, "_valid"}, kif.key_valid, 8'd0);
      check({tag, "_held"}, kif.key_held, 8'd0);
      check({tag, "_code"}, kif.key_code, 8'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t        vecs[$];
   logic [5:0]  e;
   logic [15:0] pat;
   int          r;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      keys      = 16'd0;
      rand_mode = 1'b1;
      rand_col  = 4'd0;
      cur_held  = 1'b0;
      cur_code  = 4'd0;
      m_held    = 1'b0;
      m_code    = 4'd0;
      m_skey    = 4'd0;
      m_slen    = 0;
      m_miss    = 0;
      pat       = 16'd0;

      vecs.push_back('{16'h0200,  2, 1'b0, 1'b0, 4'h0});
      vecs.push_back('{16'h0200,  1, 1'b1, 1'b1, 4'h9});
      vecs.push_back('{16'h0200, 10, 1'b0, 1'b1, 4'h9});
      vecs.push_back('{16'h0000,  2, 1'b0, 1'b1, 4'h9});
      vecs.push_back('{16'h0000,  1, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0000,  2, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0200,  2, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0000,  1, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0200,  2, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0000,  2, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h8001,  5, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0001,  2, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0001,  1, 1'b1, 1'b1, 4'h0});
      vecs.push_back('{16'h0000,  2, 1'b0, 1'b1, 4'h0});
      vecs.push_back('{16'h0001,  2, 1'b0, 1'b1, 4'h0});
      vecs.push_back('{16'h0020,  2, 1'b0, 1'b1, 4'h0});
      vecs.push_back('{16'h0020,  1, 1'b0, 1'b0, 4'h0});
      vecs.push_back('{16'h0020,  2, 1'b0, 1'b0, 4'h0});
      vecs.push_back('{16'h0020,  1, 1'b1, 1'b1, 4'h5});
      vecs.push_back('{16'h0000,  2, 1'b0, 1'b1, 4'h5});
      vecs.push_back('{16'h0000,  1, 1'b0, 1'b0, 4'h5});
      vecs.push_back('{16'h0008,  1, 1'b0, 1'b0, 4'h5});
      vecs.push_back('{16'h0040,  2, 1'b0, 1'b0, 4'h5});
      vecs.push_back('{16'h0040,  1, 1'b1, 1'b1, 4'h6});
      vecs.push_back('{16'h0000,  2, 1'b0, 1'b1, 4'h6});
      vecs.push_back('{16'h0000,  1, 1'b0, 1'b0, 4'h6});

      // Reset held with random column noise.
      reset = 1'b1;
      #2 reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rand_col = 4'($urandom_range(0, 15));
         @(negedge clk);
         check_reset_outputs("in_reset");
      end

      // Release: row strobe walks 0001,0010,0100,1000 with SCAN_DIV cycles each.
      rand_mode = 1'b0;
      keys      = 16'd0;
      reset     = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         check("row_seq", kif.row, 8'h01 << ((k / SCAN_DIV) % 4));
         check("idle_valid", kif.key_valid, 8'd0);
         check("idle_held", kif.key_held, 8'd0);
         @(negedge clk);
      end

      for (int v = 0; v < vecs.size(); v++) begin
         for (int n = 0; n < vecs[v].reps; n++) begin
            model_step(vecs[v].keys, e);
            exp_q.push_back({vecs[v].valid, vecs[v].held, vecs[v].code});
            run_frame(vecs[v].keys);
         end
      end

      // Reset during PRESS_WAIT with two matching frames already counted.
      for (int n = 0; n < 2; n++) begin
         exp_q.push_back({1'b0, 1'b0, cur_code});
         run_frame(16'h0200);
      end
      for (int c = 0; c < 7; c++) @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_reset_outputs("mid_reset");
      end
      reset    = 1'b1;
      cur_held = 1'b0;
      cur_code = 4'h0;
      exp_q.push_back({1'b0, 1'b0, 4'h0});
      exp_q.push_back({1'b0, 1'b0, 4'h0});
      exp_q.push_back({1'b1, 1'b1, 4'h9});
      for (int n = 0; n < 3; n++) run_frame(16'h0200);

      m_held = 1'b1;
      m_code = 4'h9;
      m_skey = 4'h9;
      m_slen = 0;
      m_miss = 0;
      pat    = 16'h0200;

      for (int f = 0; f < 150; f++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            pat = pat;
         end else if (r < 6) begin
            pat = 16'd0;
         end else if (r < 9) begin
            pat = 16'd1 << $urandom_range(0, 15);
         end else begin
            pat = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         end
         model_step(pat, e);
         exp_q.push_back(e);
         run_frame(pat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
